// File: rtl/midi_pkg.sv
// midi_pkg: shared status nibbles, FSM state types and bit-timing helper for the MIDI note transmitter
package midi_pkg;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON = 4'h9;
  typedef enum logic [1:0] {IDLE, SEND_STATUS, SEND_NOTE, SEND_VEL} msg_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} byte_state_t;
  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer, one byte per tx_valid/tx_ready handshake (ready in IDLE and on the last stop-bit cycle), idle-high tx
module uart_tx_byte
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       tx
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  byte_state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_idx, w_idx_next;
  logic [7:0] r_data;
  logic r_tx, w_tx, w_bit_end, w_load;
  assign w_bit_end = r_cnt == LAST;
  assign tx_ready = r_state == TX_IDLE || (r_state == TX_STOP && w_bit_end);
  assign w_load = tx_valid && tx_ready;
  assign tx = r_tx;
  always_comb begin
    w_next = r_state;
    case (r_state)
      TX_IDLE:  w_next = w_load ? TX_START : TX_IDLE;
      TX_START: w_next = w_bit_end ? TX_DATA : TX_START;
      TX_DATA:  w_next = (w_bit_end && r_idx == 3'd7) ? TX_STOP : TX_DATA;
      TX_STOP:  w_next = w_bit_end ? (w_load ? TX_START : TX_IDLE) : TX_STOP;
      default:  w_next = TX_IDLE;
    endcase
    w_idx_next = (r_state == TX_DATA && w_bit_end) ? r_idx + 3'd1 : r_idx;
    w_tx = w_next == TX_START ? 1'b0 : w_next == TX_DATA ? r_data[w_idx_next] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == TX_IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
      r_idx   <= w_idx_next;
      r_tx    <= w_tx;
      if (w_load) r_data <= tx_data;
    end
  end
endmodule

// File: rtl/midi_note_tx.sv
// midi_note_tx: accepts note on/off commands (cmd_*), sequences status/note/velocity bytes with optional running status onto uart_tx; busy while a message is in flight
module midi_note_tx
  import midi_pkg::*;
#(
  parameter int CLOCK_FREQ     = 100_000_000,
  parameter int BAUD_RATE      = 9600,
  parameter int RUNNING_STATUS = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_note_on,
  input  logic [3:0] cmd_channel,
  input  logic [6:0] cmd_note,
  input  logic [6:0] cmd_velocity,
  output logic       uart_tx,
  output logic       busy
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  msg_state_t r_state, w_next, w_succ, w_byte_sel;
  logic r_sent, r_last_vld;
  logic [7:0] r_status, r_last, w_status, w_tx_data;
  logic [6:0] r_note, r_vel;
  logic w_accept, w_skip, w_tx_valid, w_tx_ready, w_hs, w_status_done;
  assign w_status = {cmd_note_on ? MIDI_NOTE_ON : MIDI_NOTE_OFF, cmd_channel};
  assign cmd_ready = r_state == IDLE && !reset;
  assign busy = r_state != IDLE;
  assign w_accept = cmd_valid && cmd_ready;
  assign w_skip = RUNNING_STATUS != 0 && r_last_vld && w_status == r_last;
  // r_sent: the current state's byte is already in the serializer, so the
  // next handshake (at its stop-bit end) hands over the following byte
  assign w_tx_valid = r_state != IDLE && (!r_sent || r_state != SEND_VEL);
  assign w_hs = w_tx_valid && w_tx_ready;
  assign w_status_done = r_state == SEND_STATUS && r_sent && w_tx_ready;
  always_comb begin
    w_succ = r_state == SEND_STATUS ? SEND_NOTE : r_state == SEND_NOTE ? SEND_VEL : IDLE;
    w_byte_sel = r_sent ? w_succ : r_state;
    w_next = r_state == IDLE ? (w_accept ? (w_skip ? SEND_NOTE : SEND_STATUS) : IDLE)
           : (r_sent && w_tx_ready) ? w_succ : r_state;
    w_tx_data = w_byte_sel == SEND_STATUS ? r_status
              : w_byte_sel == SEND_NOTE ? {1'b0, r_note} : {1'b0, r_vel};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_sent     <= 1'b0;
      r_status   <= '0;
      r_note     <= '0;
      r_vel      <= '0;
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sent  <= r_state != IDLE && (r_sent || w_hs);
      if (w_accept) begin
        r_status <= w_status;
        r_note   <= cmd_note;
        r_vel    <= cmd_velocity;
      end
      if (w_status_done) begin
        r_last     <= r_status;
        r_last_vld <= 1'b1;
      end
    end
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk     (clk),
    .reset   (reset),
    .tx_valid(w_tx_valid),
    .tx_ready(w_tx_ready),
    .tx_data (w_tx_data),
    .tx      (uart_tx)
  );
endmodule

// File: tb/tb_midi_note_tx.sv
// tb_midi_note_tx: directed checks of message bytes, bit timing, running status, backpressure and mid-message reset
module tb_midi_note_tx;
  localparam int CPB = 16;
  logic clk = 0, reset = 1, v1 = 0, v0 = 0, sel = 0;
  logic on = 0;
  logic [3:0] ch = 0;
  logic [6:0] note = 0, vel = 0;
  logic ready1, ready0, tx1, tx0, busy1, busy0, w_ready, w_tx, w_busy;
  logic line [0:30*CPB-1];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign w_ready = sel ? ready0 : ready1;
  assign w_tx = sel ? tx0 : tx1;
  assign w_busy = sel ? busy0 : busy1;
  midi_note_tx #(.CLOCK_FREQ(CPB * 100), .BAUD_RATE(100), .RUNNING_STATUS(1)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(v1), .cmd_ready(ready1), .cmd_note_on(on),
    .cmd_channel(ch), .cmd_note(note), .cmd_velocity(vel), .uart_tx(tx1), .busy(busy1));
  midi_note_tx #(.CLOCK_FREQ(CPB * 100), .BAUD_RATE(100), .RUNNING_STATUS(0)) u_dut0 (
    .clk(clk), .reset(reset), .cmd_valid(v0), .cmd_ready(ready0), .cmd_note_on(on),
    .cmd_channel(ch), .cmd_note(note), .cmd_velocity(vel), .uart_tx(tx0), .busy(busy0));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic msg(input logic rs0, input logic n_on, input logic [3:0] n_ch, input logic [6:0] n_note,
                     input logic [6:0] n_vel, input int n, input logic [7:0] e0, input logic [7:0] e1,
                     input logic [7:0] e2, input int abort_at, input logic bp);
    int t = 0;
    logic ready_bad = 0, idle_bad = 0;
    sel = rs0; on = n_on; ch = n_ch; note = n_note; vel = n_vel;
    while (!w_ready && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    chk("ready_wait", w_ready, 1);
    if (rs0) v0 = 1; else v1 = 1;
    @(posedge clk); #1;
    if (!bp) begin v0 = 0; v1 = 0; end
    chk("ready_drop", w_ready, 0);
    chk("busy_set", w_busy, 1);
    @(posedge clk); #1;
    chk("start_lat", w_tx, 0);
    line[0] = w_tx;
    for (int i = 1; i < n * 10 * CPB; i++) begin
      @(posedge clk); #1;
      line[i] = w_tx;
      if (w_ready) ready_bad = 1;
      if (bp) note = 7'(i);
      if (i == abort_at) begin
        reset = 1;
        @(posedge clk); #1;
        chk("abort_tx", w_tx, 1);
        chk("abort_busy", w_busy, 0);
        chk("abort_rdy_rst", w_ready, 0);
        reset = 0;
        @(posedge clk); #1;
        chk("abort_ready", w_ready, 1);
        repeat (2 * CPB) begin
          @(posedge clk); #1;
          if (w_tx !== 1'b1 || w_busy !== 1'b0) idle_bad = 1;
        end
        chk("abort_idle", idle_bad, 0);
        return;
      end
    end
    chk("ready_low", ready_bad, 0);
    @(posedge clk); #1;
    chk("ready_ret", w_ready, 1);
    chk("busy_clr", w_busy, 0);
    if (bp) begin
      v0 = 0; v1 = 0;
      @(posedge clk); #1;
      chk("no_extra", w_busy, 0);
    end
    for (int b = 0; b < n; b++) begin
      logic [7:0] val = 0, exp;
      logic hold_bad = 0;
      int base = b * 10 * CPB;
      exp = b == 0 ? e0 : b == 1 ? e1 : e2;
      for (int k = 0; k < 10; k++) begin
        logic mid = line[base + k * CPB + CPB / 2];
        for (int j = 0; j < CPB; j++) if (line[base + k * CPB + j] !== mid) hold_bad = 1;
        if (k >= 1 && k <= 8) val[k-1] = mid;
      end
      chk("start_bit", line[base + CPB / 2], 0);
      chk("stop_bit", line[base + 9 * CPB + CPB / 2], 1);
      chk("bit_hold", hold_bad, 0);
      chk("byte", val, exp);
    end
  endtask
  initial begin
    logic bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (tx1 !== 1'b1 || tx0 !== 1'b1 || ready1 !== 1'b0) bad = 1;
    end
    chk("rst_hold", bad, 0);
    chk("rst_busy", busy1, 0);
    reset = 0;
    @(posedge clk); #1;
    chk("rel_ready", ready1, 1);
    chk("rel_busy", busy1, 0);
    chk("rel_tx", tx1, 1);
    msg(0, 1, 4'd0, 7'h3C, 7'h7F, 3, 8'h90, 8'h3C, 8'h7F, -1, 0);
    msg(0, 0, 4'd5, 7'h40, 7'h00, 3, 8'h85, 8'h40, 8'h00, -1, 0);
    msg(0, 1, 4'd0, 7'h40, 7'h7F, 3, 8'h90, 8'h40, 8'h7F, -1, 0);
    msg(0, 1, 4'd0, 7'h43, 7'h7F, 2, 8'h43, 8'h7F, 8'h00, -1, 0);
    msg(0, 0, 4'd0, 7'h43, 7'h40, 3, 8'h80, 8'h43, 8'h40, -1, 0);
    msg(0, 0, 4'd0, 7'h10, 7'h20, 2, 8'h10, 8'h20, 8'h00, -1, 1);
    msg(0, 1, 4'd1, 7'h50, 7'h01, 3, 8'h91, 8'h50, 8'h01, 10 * CPB + 4 * CPB + CPB / 2, 0);
    msg(0, 1, 4'd1, 7'h50, 7'h01, 3, 8'h91, 8'h50, 8'h01, -1, 0);
    msg(0, 1, 4'd1, 7'h51, 7'h00, 2, 8'h51, 8'h00, 8'h00, -1, 0);
    msg(1, 1, 4'd0, 7'h3C, 7'h7F, 3, 8'h90, 8'h3C, 8'h7F, -1, 0);
    msg(1, 1, 4'd0, 7'h3E, 7'h11, 3, 8'h90, 8'h3E, 8'h11, -1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
